// File: rtl/fetch_line_unit.sv
// Instruction-fetch front end: line-sized Sysbus reads split into 32-bit words and queued with their PCs.
// Optional FETCH_TRACE_EN prints every enqueued word and the halt event; the logic is the same either way.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif

module fetch_line_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect,
  input  logic [63:0]               redirect_pc,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [63:0]               inst_pc,
  output logic                      halted
);
  localparam int IPB        = BUS_DATA_WIDTH / 32;
  localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
  localparam int LINE_BYTES = LINE_BEATS * BEAT_BYTES;
  localparam int LINE_WORDS = LINE_BEATS * IPB;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int TAG_VAL    = (`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HALT} state_t;

  state_t            r_state;
  logic [63:0]       r_pc, r_line;
  logic              r_reqcyc, r_redir_pend, r_zero_seen, r_halted;
  logic [BEAT_W-1:0] r_beat;
  logic [PTR_W-1:0]  r_rptr, r_wptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_inst;
  logic [63:0]       r_inst_pc;
  logic [31:0]       r_mem_inst [FIFO_DEPTH];
  logic [63:0]       r_mem_pc   [FIFO_DEPTH];

  logic              w_beat_acc, w_last_beat, w_enq_ok, w_zero_any, w_zero_hit;
  logic              w_pop, w_free_ok, w_unused_tag;
  logic [63:0]       w_beat_base;
  logic [31:0]       w_word   [IPB];
  logic [63:0]       w_addr   [IPB];
  logic              w_wr_en  [IPB];
  logic [PTR_W-1:0]  w_wr_idx [IPB];
  logic [CNT_W-1:0]  w_nwr, w_count_next;
  logic [PTR_W-1:0]  w_rptr_next;
  logic [31:0]       w_head_inst;
  logic [63:0]       w_head_pc;

  assign bus_reqtag   = BUS_TAG_WIDTH'(TAG_VAL);
  assign bus_reqcyc   = r_reqcyc;
  assign bus_req      = BUS_DATA_WIDTH'(r_line);
  assign bus_respack  = bus_respcyc && (r_state == S_WAIT || r_state == S_DRAIN);
  assign inst_valid   = (r_count != '0);
  assign inst         = r_inst;
  assign inst_pc      = r_inst_pc;
  assign halted       = r_halted;
  assign w_unused_tag = ^bus_resptag;

  assign w_beat_acc   = bus_respcyc && bus_respack;
  assign w_last_beat  = (r_beat == BEAT_W'(LINE_BEATS - 1));
  assign w_enq_ok     = (r_state == S_WAIT) && w_beat_acc && !redirect;
  assign w_beat_base  = r_line + (64'(r_beat) * 64'(BEAT_BYTES));
  assign w_zero_hit   = w_enq_ok && w_zero_any;
  assign w_pop        = inst_valid && inst_ready;
  assign w_free_ok    = (CNT_W'(FIFO_DEPTH) - r_count) >= CNT_W'(LINE_WORDS);
  assign w_count_next = redirect ? '0 : r_count + w_nwr - CNT_W'(w_pop);
  assign w_rptr_next  = redirect ? '0 : r_rptr + PTR_W'(w_pop);

  // Words below pc are skipped; the first eligible zero word kills itself and the rest of the line.
  always_comb begin
    logic             v_seen;
    logic             v_elig;
    logic [CNT_W-1:0] v_off;
    v_seen     = r_zero_seen;
    v_elig     = 1'b0;
    v_off      = '0;
    w_zero_any = 1'b0;
    for (int k = 0; k < IPB; k++) begin
      w_word[k] = bus_resp[32*k +: 32];
      w_addr[k] = w_beat_base + 64'(4 * k);
      v_elig    = (w_addr[k] >= r_pc);
      if (v_elig && w_word[k] == 32'h0) begin
        v_seen     = 1'b1;
        w_zero_any = 1'b1;
      end
      w_wr_en[k]  = w_enq_ok && v_elig && !v_seen;
      w_wr_idx[k] = r_wptr + PTR_W'(v_off);
      if (w_wr_en[k]) v_off = v_off + CNT_W'(1);
    end
    w_nwr = v_off;
  end

  // The head register may need a word that is only being written this cycle.
  always_comb begin
    w_head_inst = r_mem_inst[w_rptr_next];
    w_head_pc   = r_mem_pc[w_rptr_next];
    for (int k = 0; k < IPB; k++) begin
      if (w_wr_en[k] && w_wr_idx[k] == w_rptr_next) begin
        w_head_inst = w_word[k];
        w_head_pc   = w_addr[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < IPB; k++) begin
      if (w_wr_en[k]) begin
        r_mem_inst[w_wr_idx[k]] <= w_word[k];
        r_mem_pc[w_wr_idx[k]]   <= w_addr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= entry;
      r_line       <= '0;
      r_reqcyc     <= 1'b0;
      r_redir_pend <= 1'b0;
      r_zero_seen  <= 1'b0;
      r_halted     <= 1'b0;
      r_beat       <= '0;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_rptr  <= w_rptr_next;
      r_wptr  <= redirect ? '0 : r_wptr + PTR_W'(w_nwr);
      r_count <= w_count_next;
      if (w_count_next != '0) begin
        r_inst    <= w_head_inst;
        r_inst_pc <= w_head_pc;
      end
      if (w_zero_hit) begin
        r_zero_seen <= 1'b1;
        r_halted    <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
          end else if (w_free_ok) begin
            r_reqcyc     <= 1'b1;
            r_line       <= r_pc & ~(64'(LINE_BYTES) - 64'd1);
            r_redir_pend <= 1'b0;
            r_zero_seen  <= 1'b0;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect) begin
            r_pc         <= redirect_pc;
            r_redir_pend <= 1'b1;
          end
          if (bus_reqack) begin
            r_reqcyc <= 1'b0;
            r_beat   <= '0;
            r_state  <= (redirect || r_redir_pend) ? S_DRAIN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_beat_acc) r_beat <= r_beat + BEAT_W'(1);
          if (redirect) begin
            r_pc        <= redirect_pc;
            r_halted    <= 1'b0;
            r_zero_seen <= 1'b0;
            if (w_beat_acc && w_last_beat) begin
              r_beat  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (w_beat_acc && w_last_beat) begin
            r_beat <= '0;
            if (r_zero_seen || w_zero_hit) begin
              r_state <= S_HALT;
            end else begin
              r_pc    <= r_line + 64'(LINE_BYTES);
              r_state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (redirect) r_pc <= redirect_pc;
          if (w_beat_acc) begin
            r_beat <= r_beat + BEAT_W'(1);
            if (w_last_beat) begin
              r_beat  <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          if (redirect) begin
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  logic [63:0] w_zero_addr;
  always_comb begin
    w_zero_addr = '0;
    for (int k = IPB - 1; k >= 0; k--)
      if (w_addr[k] >= r_pc && w_word[k] == 32'h0) w_zero_addr = w_addr[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < IPB; k++)
        if (w_wr_en[k]) $display("%h: %h", w_addr[k], w_word[k]);
      if (w_zero_hit && !r_halted) $display("fetch halted at %h", w_zero_addr);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_line_unit.sv
// Directed bench for fetch_line_unit: a one-outstanding-request memory model plus pop/request monitors.
module tb_fetch_line_unit;
  localparam logic [63:0] NO_ZERO = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] entry = 64'h1000;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack = 1'b0;
  logic        bus_respcyc = 1'b0;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  logic        bus_respack;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        halted;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] zero_addr = NO_ZERO;
  int          ack_delay = 0;
  int          beats_acked = 0;
  logic [63:0] req_log [$];
  logic [63:0] pop_pc [$];
  logic [31:0] pop_inst [$];

  fetch_line_unit dut (
    .clk(clk), .reset(reset), .entry(entry), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == zero_addr) return 32'h0;
    return 32'hC300_0000 | {8'h00, a[23:0]};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory model: inputs change on the falling edge, handshakes are sampled just before the rising edge.
  initial begin
    logic        m_active, req_taken, beat_taken;
    logic [63:0] m_line;
    int          m_beat, m_hold;
    m_active = 0; req_taken = 0; beat_taken = 0; m_line = '0; m_beat = 0; m_hold = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_active = 0; m_beat = 0; m_hold = 0;
        bus_reqack = 0; bus_respcyc = 0;
      end else begin
        if (req_taken) begin
          m_active = 1; m_line = bus_req; m_beat = 0; m_hold = 0;
        end
        if (beat_taken) begin
          m_beat++;
          beats_acked++;
          if (m_beat == 8) m_active = 0;
        end
        bus_reqack = bus_reqcyc && !m_active && (m_hold >= ack_delay);
        if (bus_reqcyc && !m_active) m_hold++;
        bus_respcyc = m_active;
        bus_resp = {mem_word(m_line + 64'(m_beat * 8) + 64'd4), mem_word(m_line + 64'(m_beat * 8))};
      end
      #4;
      req_taken  = reset && bus_reqack && bus_reqcyc;
      beat_taken = reset && bus_respcyc && bus_respack;
      if (req_taken) req_log.push_back(bus_req);
      if (reset && inst_valid && inst_ready) begin
        pop_pc.push_back(inst_pc);
        pop_inst.push_back(inst);
      end
    end
  end

  task automatic do_reset(input logic [63:0] e, input logic [63:0] z, input logic rdy);
    reset = 1'b0;
    redirect = 1'b0;
    entry = e;
    zero_addr = z;
    inst_ready = rdy;
    ack_delay = 0;
    repeat (3) tick();
    check_val("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check_val("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_val("rst_halted", 64'(halted), 64'd0);
    check_val("rst_respack", 64'(bus_respack), 64'd0);
    req_log.delete();
    pop_pc.delete();
    pop_inst.delete();
    beats_acked = 0;
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_val("rst_req", bus_req, 64'd0);
    check_val("rst_inst", 64'(inst), 64'd0);
    check_val("rst_inst_pc", inst_pc, 64'd0);
    check_val("rst_tag", 64'(bus_reqtag), 64'h1100);

    // 1: aligned entry, two lines in order
    do_reset(64'h1000, NO_ZERO, 1'b1);
    for (int i = 0; i < 300 && (pop_pc.size() < 16 || req_log.size() < 2); i++) tick();
    check_val("t1_pops", 64'(pop_pc.size() >= 16), 64'd1);
    check_val("t1_req0", (req_log.size() > 0) ? req_log[0] : 64'hX, 64'h1000);
    check_val("t1_req1", (req_log.size() > 1) ? req_log[1] : 64'hX, 64'h1040);
    for (int i = 0; i < 16 && i < pop_pc.size(); i++) begin
      check_val($sformatf("t1_pc%0d", i), pop_pc[i], 64'h1000 + 64'(4 * i));
      check_val($sformatf("t1_inst%0d", i), 64'(pop_inst[i]), 64'(mem_word(64'h1000 + 64'(4 * i))));
    end

    // 2: unaligned entry drops the first two words (reset lands mid-line of test 1)
    do_reset(64'h1008, NO_ZERO, 1'b1);
    for (int i = 0; i < 300 && pop_pc.size() < 15; i++) tick();
    check_val("t2_pops", 64'(pop_pc.size() >= 15), 64'd1);
    check_val("t2_req0", (req_log.size() > 0) ? req_log[0] : 64'hX, 64'h1000);
    check_val("t2_first", (pop_pc.size() > 0) ? pop_pc[0] : 64'hX, 64'h1008);
    check_val("t2_last", (pop_pc.size() > 13) ? pop_pc[13] : 64'hX, 64'h103C);
    check_val("t2_next", (pop_pc.size() > 14) ? pop_pc[14] : 64'hX, 64'h1040);

    // 3: zero word at 0x1014 halts fetch
    do_reset(64'h1000, 64'h1014, 1'b1);
    for (int i = 0; i < 300 && !(halted && beats_acked == 8); i++) tick();
    repeat (20) tick();
    check_val("t3_halted", 64'(halted), 64'd1);
    check_val("t3_beats", 64'(beats_acked), 64'd8);
    check_val("t3_pops", 64'(pop_pc.size()), 64'd5);
    check_val("t3_last_pc", (pop_pc.size() > 4) ? pop_pc[4] : 64'hX, 64'h1010);
    check_val("t3_last_inst", (pop_inst.size() > 4) ? 64'(pop_inst[4]) : 64'hX, 64'(mem_word(64'h1010)));
    check_val("t3_nreq", 64'(req_log.size()), 64'd1);
    check_val("t3_reqcyc", 64'(bus_reqcyc), 64'd0);

    // 4: decoder stalled, FIFO fills with exactly two lines
    do_reset(64'h1000, NO_ZERO, 1'b0);
    repeat (100) tick();
    check_val("t4_nreq", 64'(req_log.size()), 64'd2);
    check_val("t4_req1", (req_log.size() > 1) ? req_log[1] : 64'hX, 64'h1040);
    check_val("t4_valid", 64'(inst_valid), 64'd1);
    check_val("t4_head", inst_pc, 64'h1000);
    inst_ready = 1'b1;
    repeat (15) tick();
    inst_ready = 1'b0;
    repeat (20) tick();
    check_val("t4_pops15", 64'(pop_pc.size()), 64'd15);
    check_val("t4_nreq_15", 64'(req_log.size()), 64'd2);
    check_val("t4_valid2", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (20) tick();
    check_val("t4_nreq_16", 64'(req_log.size()), 64'd3);
    check_val("t4_req2", (req_log.size() > 2) ? req_log[2] : 64'hX, 64'h1080);

    // 5: redirect while beat 4 is on the bus
    do_reset(64'h1000, NO_ZERO, 1'b0);
    for (int i = 0; i < 200 && beats_acked < 4; i++) tick();
    check_val("t5_beats", 64'(beats_acked), 64'd4);
    check_val("t5_valid_pre", 64'(inst_valid), 64'd1);
    redirect = 1'b1;
    redirect_pc = 64'h2000;
    tick();
    redirect = 1'b0;
    check_val("t5_flushed", 64'(inst_valid), 64'd0);
    for (int i = 0; i < 200 && req_log.size() < 2; i++) tick();
    check_val("t5_drained", 64'(beats_acked), 64'd8);
    check_val("t5_req1", (req_log.size() > 1) ? req_log[1] : 64'hX, 64'h2000);
    repeat (20) tick();
    check_val("t5_head_pc", inst_pc, 64'h2000);
    check_val("t5_head_inst", 64'(inst), 64'(mem_word(64'h2000)));

    // 6: redirect out of HALT with a slow request acknowledge
    do_reset(64'h1000, 64'h1014, 1'b1);
    for (int i = 0; i < 300 && !(halted && beats_acked == 8); i++) tick();
    repeat (5) tick();
    check_val("t6_halted_pre", 64'(halted), 64'd1);
    ack_delay = 5;
    zero_addr = NO_ZERO;
    redirect = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    redirect = 1'b0;
    check_val("t6_halted_clr", 64'(halted), 64'd0);
    begin
      int   hi;
      logic stable;
      hi = 0;
      stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (bus_reqcyc) begin
          hi++;
          if (bus_req !== 64'h3000) stable = 1'b0;
        end else if (hi > 0) begin
          break;
        end
        tick();
      end
      check_val("t6_reqcyc_cycles", 64'(hi), 64'd6);
      check_val("t6_req_stable", 64'(stable), 64'd1);
    end
    check_val("t6_req_logged", (req_log.size() > 1) ? req_log[1] : 64'hX, 64'h3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end
endmodule
